// File: rtl/stack_rpn_engine.sv
// Reverse-Polish evaluator: accepts operand/operator tokens, masters an external
// LIFO stack via push/pop requests, and strobes each operator result.
module stack_rpn_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 token_valid,
  output logic                 token_ready,
  input  logic                 token_is_op,
  input  logic [1:0]           token_op,
  input  logic [WIDTH-1:0]     token_data,
  output logic                 stack_write_req,
  output logic [WIDTH-1:0]     stack_write_data,
  output logic                 stack_read_req,
  input  logic [WIDTH-1:0]     stack_read_data,
  output logic                 result_valid,
  output logic [WIDTH-1:0]     result_data,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic [DEPTH_LOG:0]   depth
);

  localparam int unsigned DW = DEPTH_LOG + 1;
  localparam logic [DW-1:0] CAPACITY = DW'(1) << DEPTH_LOG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_B,
    S_POP_A,
    S_CAP_A,
    S_EXEC
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_ovf;
  logic             w_unf;
  logic [WIDTH-1:0] w_result;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_result;
  logic [DW-1:0]    r_depth;
  logic             r_ready;
  logic             r_wr;
  logic             r_rd;
  logic             r_rv;
  logic             r_ovf;
  logic             r_unf;

  assign w_accept = token_valid && (r_state == S_IDLE);

  // Next-state and error decode; errors drop the token and stay in IDLE
  always_comb begin
    w_next = r_state;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!token_is_op) begin
            if (r_depth == CAPACITY) w_ovf  = 1'b1;
            else                     w_next = S_PUSH;
          end else begin
            if (r_depth < DW'(2)) w_unf  = 1'b1;
            else                  w_next = S_POP_B;
          end
        end
      end
      S_PUSH:  w_next = S_IDLE;
      S_POP_B: w_next = S_POP_A;
      S_POP_A: w_next = S_CAP_A;
      S_CAP_A: w_next = S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A (deeper entry) arrives on stack_read_data during CAP_A; B was captured earlier
  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = stack_read_data + r_b;
      2'b01:   w_result = stack_read_data - r_b;
      2'b10:   w_result = stack_read_data & r_b;
      default: w_result = stack_read_data | r_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_b      <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_depth  <= '0;
      r_ready  <= 1'b1;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_rv     <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_wr    <= (w_next == S_PUSH) || (w_next == S_EXEC);
      r_rd    <= (w_next == S_POP_B) || (w_next == S_POP_A);
      r_rv    <= (w_next == S_EXEC);
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
      if (w_next == S_PUSH && r_state == S_IDLE)  r_wdata <= token_data;
      if (w_next == S_POP_B && r_state == S_IDLE) r_op    <= token_op;
      if (r_state == S_POP_A) r_b <= stack_read_data;
      if (r_state == S_CAP_A) begin
        r_result <= w_result;
        r_wdata  <= w_result;
      end
      case (r_state)
        S_PUSH, S_EXEC:   r_depth <= r_depth + DW'(1);
        S_POP_B, S_POP_A: r_depth <= r_depth - DW'(1);
        default:          r_depth <= r_depth;
      endcase
    end
  end

  assign token_ready      = r_ready;
  assign stack_write_req  = r_wr;
  assign stack_write_data = r_wdata;
  assign stack_read_req   = r_rd;
  assign result_valid     = r_rv;
  assign result_data      = r_result;
  assign err_overflow     = r_ovf;
  assign err_underflow    = r_unf;
  assign depth            = r_depth;

endmodule

// File: tb/tb_stack_rpn_engine.sv
// Self-checking bench for stack_rpn_engine: behavioural LIFO stack environment,
// queue-based RPN reference model, directed scenarios plus randomized token stream.
module tb_stack_rpn_engine;

  localparam int W   = 8;
  localparam int DL  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          token_valid;
  logic          token_ready;
  logic          token_is_op;
  logic [1:0]    token_op;
  logic [W-1:0]  token_data;
  logic          stack_write_req;
  logic [W-1:0]  stack_write_data;
  logic          stack_read_req;
  logic [W-1:0]  stack_read_data;
  logic          result_valid;
  logic [W-1:0]  result_data;
  logic          err_overflow;
  logic          err_underflow;
  logic [DL:0]   depth;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_rpn_engine #(.WIDTH(W), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .token_valid(token_valid), .token_ready(token_ready),
    .token_is_op(token_is_op), .token_op(token_op), .token_data(token_data),
    .stack_write_req(stack_write_req), .stack_write_data(stack_write_data),
    .stack_read_req(stack_read_req), .stack_read_data(stack_read_data),
    .result_valid(result_valid), .result_data(result_data),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .depth(depth)
  );

  // Environment: the downstream LIFO stack, data valid the cycle after a pop
  logic [W-1:0] env_stk[$];
  logic [W-1:0] env_rd;
  assign stack_read_data = env_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_stk.delete();
      env_rd <= '0;
    end else begin
      if (stack_write_req) env_stk.push_back(stack_write_data);
      if (stack_read_req && env_stk.size() > 0) begin
        env_rd <= env_stk[$];
        void'(env_stk.pop_back());
      end
    end
  end

  // Reference model: expression stack; kind 0 push, 1 overflow, 2 underflow, 3 result
  logic [W-1:0] ref_stk[$];

  function automatic int ref_apply(input bit is_op, input logic [1:0] op,
                                   input logic [W-1:0] d, output logic [W-1:0] r);
    logic [W-1:0] a, b;
    r = '0;
    if (!is_op) begin
      if (ref_stk.size() == CAP) return 1;
      ref_stk.push_back(d);
      r = d;
      return 0;
    end
    if (ref_stk.size() < 2) return 2;
    b = ref_stk.pop_back();
    a = ref_stk.pop_back();
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    ref_stk.push_back(r);
    return 3;
  endfunction

  typedef struct {
    int           n_res;
    logic [W-1:0] res;
    int           res_k;
    int           n_wr;
    int           n_rd;
    int           n_both;
    int           n_ovf;
    int           n_unf;
    logic [W-1:0] wdata;
    int           ready_k;
    int           dmin;
  } obs_t;

  task automatic do_reset();
    token_valid = 1'b0;
    token_is_op = 1'b0;
    token_op    = 2'b00;
    token_data  = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_stk.delete();
    @(negedge clk);
  endtask

  // Present one token, then record DUT activity for the six cycles after acceptance
  task automatic run_token(input bit is_op, input logic [1:0] op,
                           input logic [W-1:0] d, output obs_t o);
    int n;
    o.n_res = 0; o.res = '0; o.res_k = 0; o.n_wr = 0; o.n_rd = 0; o.n_both = 0;
    o.n_ovf = 0; o.n_unf = 0; o.wdata = '0; o.ready_k = 0; o.dmin = 99;
    @(negedge clk);
    token_valid = 1'b1; token_is_op = is_op; token_op = op; token_data = d;
    n = 0;
    while (!token_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL accept_timeout: token_ready stayed %0b, required 1", token_ready);
    end
    @(posedge clk);
    @(negedge clk);
    token_valid = 1'b0;
    token_data  = W'($urandom);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (result_valid) begin
        if (o.n_res == 0) begin o.res = result_data; o.res_k = k; end
        o.n_res++;
      end
      if (stack_write_req) begin o.n_wr++; o.wdata = stack_write_data; end
      if (stack_read_req) o.n_rd++;
      if (stack_read_req && stack_write_req) o.n_both++;
      if (err_overflow) o.n_ovf++;
      if (err_underflow) o.n_unf++;
      if (token_ready && o.ready_k == 0) o.ready_k = k;
      if (int'(depth) < o.dmin) o.dmin = int'(depth);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({depth, token_ready, stack_write_req, stack_read_req, result_valid,
         err_overflow, err_underflow, result_data} !== {5'd0, 1'b1, 5'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: depth=%0d rdy=%0b wr=%0b rd=%0b rv=%0b ovf=%0b unf=%0b res=%0h, required 0 1 0 0 0 0 0 0",
               depth, token_ready, stack_write_req, stack_read_req, result_valid,
               err_overflow, err_underflow, result_data);
    end
  endtask

  task automatic test_add();
    obs_t o;
    logic [W-1:0] r;
    int kind;
    do_reset();
    run_token(1'b0, 2'b00, 8'd3, o); kind = ref_apply(1'b0, 2'b00, 8'd3, r);
    checks++;
    if (o.n_wr !== 1 || o.wdata !== 8'd3 || o.ready_k !== 2 || depth !== 5'd1) begin
      failures++;
      $display("FAIL push3: wr=%0d data=%0h ready_k=%0d depth=%0d, required 1 03 2 1",
               o.n_wr, o.wdata, o.ready_k, depth);
    end
    run_token(1'b0, 2'b00, 8'd4, o); kind = ref_apply(1'b0, 2'b00, 8'd4, r);
    checks++;
    if (depth !== 5'd2) begin
      failures++; $display("FAIL push4_depth: depth=%0d, required 2", depth);
    end
    run_token(1'b1, 2'b00, 8'h00, o); kind = ref_apply(1'b1, 2'b00, 8'h00, r);
    checks++;
    if (o.n_res !== 1 || o.res !== 8'd7 || o.res_k !== 4 || o.n_rd !== 2 ||
        o.ready_k !== 5 || o.dmin !== 0 || depth !== 5'd1) begin
      failures++;
      $display("FAIL add_3_4: n_res=%0d res=%0h k=%0d rd=%0d ready_k=%0d dmin=%0d depth=%0d, required 1 07 4 2 5 0 1",
               o.n_res, o.res, o.res_k, o.n_rd, o.ready_k, o.dmin, depth);
    end
  endtask

  task automatic test_sub_wrap();
    obs_t o;
    logic [W-1:0] r;
    int kind;
    do_reset();
    run_token(1'b0, 2'b00, 8'd2, o); kind = ref_apply(1'b0, 2'b00, 8'd2, r);
    run_token(1'b0, 2'b00, 8'd5, o); kind = ref_apply(1'b0, 2'b00, 8'd5, r);
    run_token(1'b1, 2'b01, 8'h00, o); kind = ref_apply(1'b1, 2'b01, 8'h00, r);
    checks++;
    if (o.n_res !== 1 || o.res !== 8'hFD || o.wdata !== 8'hFD) begin
      failures++;
      $display("FAIL sub_wrap: n_res=%0d res=%0h push=%0h, required 1 fd fd", o.n_res, o.res, o.wdata);
    end
    run_token(1'b0, 2'b00, 8'hFF, o); kind = ref_apply(1'b0, 2'b00, 8'hFF, r);
    run_token(1'b1, 2'b00, 8'h00, o); kind = ref_apply(1'b1, 2'b00, 8'h00, r);
    checks++;
    if (o.res !== 8'hFC || result_data !== 8'hFC || depth !== 5'd1) begin
      failures++;
      $display("FAIL add_carry: res=%0h held=%0h depth=%0d, required fc fc 1", o.res, result_data, depth);
    end
  endtask

  task automatic test_logic();
    obs_t o;
    logic [W-1:0] r;
    int kind;
    do_reset();
    run_token(1'b0, 2'b00, 8'hF0, o); kind = ref_apply(1'b0, 2'b00, 8'hF0, r);
    run_token(1'b0, 2'b00, 8'h3C, o); kind = ref_apply(1'b0, 2'b00, 8'h3C, r);
    run_token(1'b1, 2'b10, 8'h00, o); kind = ref_apply(1'b1, 2'b10, 8'h00, r);
    checks++;
    if (o.res !== 8'h30) begin
      failures++; $display("FAIL and: res=%0h, required 30", o.res);
    end
    run_token(1'b0, 2'b00, 8'h0F, o); kind = ref_apply(1'b0, 2'b00, 8'h0F, r);
    run_token(1'b1, 2'b11, 8'h00, o); kind = ref_apply(1'b1, 2'b11, 8'h00, r);
    checks++;
    if (o.res !== 8'h3F || depth !== 5'd1 || env_stk.size() != 1) begin
      failures++;
      $display("FAIL or: res=%0h depth=%0d stack_entries=%0d, required 3f 1 1", o.res, depth, env_stk.size());
    end
  endtask

  task automatic test_underflow();
    obs_t o;
    logic [W-1:0] r;
    int kind;
    do_reset();
    run_token(1'b1, 2'b00, 8'h00, o); kind = ref_apply(1'b1, 2'b00, 8'h00, r);
    checks++;
    if (o.n_unf !== 1 || o.n_wr !== 0 || o.n_rd !== 0 || o.n_res !== 0 ||
        o.ready_k !== 1 || depth !== 5'd0) begin
      failures++;
      $display("FAIL underflow_empty: unf=%0d wr=%0d rd=%0d res=%0d ready_k=%0d depth=%0d, required 1 0 0 0 1 0",
               o.n_unf, o.n_wr, o.n_rd, o.n_res, o.ready_k, depth);
    end
    run_token(1'b0, 2'b00, 8'd1, o); kind = ref_apply(1'b0, 2'b00, 8'd1, r);
    run_token(1'b1, 2'b00, 8'h00, o); kind = ref_apply(1'b1, 2'b00, 8'h00, r);
    checks++;
    if (o.n_unf !== 1 || o.n_rd !== 0 || depth !== 5'd1) begin
      failures++;
      $display("FAIL underflow_one: unf=%0d rd=%0d depth=%0d, required 1 0 1", o.n_unf, o.n_rd, depth);
    end
  endtask

  task automatic test_overflow();
    obs_t o;
    logic [W-1:0] r;
    logic [W-1:0] vals[CAP];
    logic [W-1:0] want;
    int kind;
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      vals[i] = W'($urandom);
      run_token(1'b0, 2'b00, vals[i], o); kind = ref_apply(1'b0, 2'b00, vals[i], r);
    end
    checks++;
    if (depth !== 5'd16) begin
      failures++; $display("FAIL fill_depth: depth=%0d, required 16", depth);
    end
    run_token(1'b0, 2'b00, 8'hAA, o); kind = ref_apply(1'b0, 2'b00, 8'hAA, r);
    checks++;
    if (o.n_ovf !== 1 || o.n_wr !== 0 || o.ready_k !== 1 || depth !== 5'd16) begin
      failures++;
      $display("FAIL overflow: ovf=%0d wr=%0d ready_k=%0d depth=%0d, required 1 0 1 16",
               o.n_ovf, o.n_wr, o.ready_k, depth);
    end
    want = vals[CAP-2] + vals[CAP-1];
    run_token(1'b1, 2'b00, 8'h00, o); kind = ref_apply(1'b1, 2'b00, 8'h00, r);
    checks++;
    if (o.n_res !== 1 || o.res !== want || depth !== 5'd15) begin
      failures++;
      $display("FAIL add_at_full: n_res=%0d res=%0h depth=%0d, required 1 %0h 15", o.n_res, o.res, depth, want);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic [W-1:0] r;
    int kind;
    int rv_seen;
    do_reset();
    run_token(1'b0, 2'b00, 8'd10, o); kind = ref_apply(1'b0, 2'b00, 8'd10, r);
    run_token(1'b0, 2'b00, 8'd20, o); kind = ref_apply(1'b0, 2'b00, 8'd20, r);
    @(negedge clk);
    token_valid = 1'b1; token_is_op = 1'b1; token_op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    token_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stack_write_req, stack_read_req, result_valid, err_overflow, err_underflow} !== 5'b0 ||
        depth !== 5'd0 || result_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: wr=%0b rd=%0b rv=%0b ovf=%0b unf=%0b depth=%0d res=%0h, required all 0",
               stack_write_req, stack_read_req, result_valid, err_overflow, err_underflow, depth, result_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_stk.delete();
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || depth !== 5'd0) begin
      failures++; $display("FAIL reset_abandon: result strobes=%0d depth=%0d, required 0 0", rv_seen, depth);
    end
    run_token(1'b0, 2'b00, 8'd9, o); kind = ref_apply(1'b0, 2'b00, 8'd9, r);
    run_token(1'b0, 2'b00, 8'd1, o); kind = ref_apply(1'b0, 2'b00, 8'd1, r);
    run_token(1'b1, 2'b01, 8'h00, o); kind = ref_apply(1'b1, 2'b01, 8'h00, r);
    checks++;
    if (o.res !== 8'd8 || depth !== 5'd1) begin
      failures++; $display("FAIL sub_after_reset: res=%0h depth=%0d, required 08 1", o.res, depth);
    end
  endtask

  // Continuous valid: only tokens seen in IDLE land, spaced two cycles apart
  task automatic test_back_to_back();
    int acc;
    logic [W-1:0] r;
    int kind;
    do_reset();
    acc = 0;
    token_valid = 1'b1; token_is_op = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      token_data = W'($urandom);
      if (token_ready) begin
        acc++;
        kind = ref_apply(1'b0, 2'b00, token_data, r);
      end
    end
    @(negedge clk);
    token_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (acc != 4 || depth !== 5'(ref_stk.size()) || env_stk != ref_stk) begin
      failures++;
      $display("FAIL back_to_back: accepted=%0d depth=%0d stack_entries=%0d, required 4 %0d %0d",
               acc, depth, env_stk.size(), ref_stk.size(), ref_stk.size());
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [W-1:0] r;
    logic [W-1:0] d;
    logic [1:0] op;
    bit is_op;
    int kind;
    bit bad;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      is_op = ($urandom_range(0, 9) < 4);
      op    = 2'($urandom);
      d     = W'($urandom);
      run_token(is_op, op, d, o);
      kind = ref_apply(is_op, op, d, r);
      case (kind)
        0:       bad = (o.n_wr != 1 || o.wdata !== r || o.n_rd != 0 || o.n_res != 0 || o.ready_k != 2);
        1:       bad = (o.n_ovf != 1 || o.n_wr != 0 || o.n_rd != 0 || o.ready_k != 1);
        2:       bad = (o.n_unf != 1 || o.n_wr != 0 || o.n_rd != 0 || o.ready_k != 1);
        default: bad = (o.n_res != 1 || o.res !== r || o.res_k != 4 || o.n_rd != 2 ||
                        o.n_wr != 1 || o.wdata !== r || o.ready_k != 5);
      endcase
      bad = bad || (o.n_both != 0) || (depth !== 5'(ref_stk.size())) ||
            (kind != 1 && o.n_ovf != 0) || (kind != 2 && o.n_unf != 0);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL random[%0d] kind=%0d: res=%0h/%0d@%0d wr=%0d(%0h) rd=%0d both=%0d ovf=%0d unf=%0d rdy_k=%0d depth=%0d; required value %0h depth %0d",
                 i, kind, o.res, o.n_res, o.res_k, o.n_wr, o.wdata, o.n_rd, o.n_both,
                 o.n_ovf, o.n_unf, o.ready_k, depth, r, ref_stk.size());
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    token_valid = 1'b0;
    token_is_op = 1'b0;
    token_op    = 2'b00;
    token_data  = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_logic();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_rpn_engine.md
Name: stack_rpn_engine

Overview:
- Reverse-Polish evaluator that sits directly upstream of the stack block and is its only master.
- Accepts a stream of operand/operator tokens over a valid/ready handshake.
- Drives the stack push/pop requests and consumes popped data.
- For each operator, emits the result on a one-cycle result strobe and pushes the result back onto the stack.

Parameters:
- WIDTH, 8, data width of operands, results and stack entries; must match the stack.
- DEPTH_LOG, 4, log2 of stack capacity; capacity = 2^DEPTH_LOG entries; must match the stack.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous reset, active low
- token_valid  input  1  token present
- token_ready  output  1  engine can accept a token this cycle
- token_is_op  input  1  1 = operator token, 0 = operand token
- token_op  input  2  operator code: 00 ADD, 01 SUB, 10 AND, 11 OR
- token_data  input  WIDTH  operand value; ignored for operators
- stack_write_req  output  1  push request to stack
- stack_write_data  output  WIDTH  push data
- stack_read_req  output  1  pop request to stack
- stack_read_data  input  WIDTH  popped value, valid the cycle after stack_read_req
- result_valid  output  1  one-cycle strobe, operator result available
- result_data  output  WIDTH  operator result
- err_overflow  output  1  one-cycle strobe, operand dropped because stack full
- err_underflow  output  1  one-cycle strobe, operator dropped because depth < 2
- depth  output  DEPTH_LOG+1  current number of stack entries

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, depth=0, operand/result registers=0.
  - All strobes and requests 0; token_ready=1 after reset deasserts.
  - A reset mid-operation abandons the operation. Partially popped values are lost and no result is produced; the stack shares rst_n and empties too.
- Handshake: token accepted on a cycle with token_valid&token_ready. token_ready=1 only in IDLE.
- FSM states:
  - IDLE:
    - Accepted operand with depth==2^DEPTH_LOG: err_overflow=1 next cycle; stay IDLE; token dropped.
    - Accepted operand otherwise: latch token_data, go to PUSH.
    - Accepted operator with depth<2: err_underflow=1 next cycle; stay IDLE; token dropped.
    - Accepted operator otherwise: latch token_op, go to POP_B.
  - PUSH: stack_write_req=1, stack_write_data=latched operand; depth+1; go to IDLE.
  - POP_B: stack_read_req=1; depth-1; go to POP_A.
  - POP_A: stack_read_req=1; depth-1; capture stack_read_data as B; go to CAP_A.
  - CAP_A: capture stack_read_data as A; go to EXEC.
  - EXEC: stack_write_req=1 with result; result_valid=1, result_data=result; depth+1; go to IDLE.
- Result computation: result = A op B, where A is the deeper entry.
  - ADD: A+B mod 2^WIDTH; carry discarded.
  - SUB: A-B mod 2^WIDTH; two's-complement wrap.
  - AND: A&B.
  - OR: A|B.
- stack_write_req and stack_read_req decode from state only, are never high together, and are never high in IDLE.
- Latency:
  - Operand accepted at cycle T: push at T+1; next token may be accepted at T+2.
  - Operator accepted at T: pops at T+1 and T+2, result strobe and push at T+4; next token at T+5.
  - Error strobes at T+1; next token may be accepted at T+1.
- result_data holds its last value until the next EXEC. Error strobes are high for exactly one cycle.
- Depth boundaries:
  - depth saturates neither way; the guards above guarantee 0 <= depth <= 2^DEPTH_LOG.
  - An operator at depth==2^DEPTH_LOG is legal: net depth change is -1.
- token_valid low, or tokens presented outside IDLE: no effect, no state change.

Test Plan:
- Reset, push 3 then 4, operator ADD -> result_valid once with result_data=7 at T+4; depth sequence 1, 2, 1, 0, 1.
- Push 2 then 5, SUB -> result_data=0xFD (2-5 wraps, WIDTH=8); push 0xFF, ADD -> result_data=0xFC.
- Push 0xF0, 0x3C; AND -> 0x30; push 0x0F; OR -> 0x3F; final depth=1.
- Reset, operator ADD -> err_underflow single pulse, no stack requests, depth=0; push 1, then ADD -> second err_underflow, depth stays 1.
- Push 16 operands (DEPTH_LOG=4) -> depth=16; 17th operand -> err_overflow, no write_req; then ADD -> result of the top two entries, depth=15.
- Assert rst_n=0 during POP_A of an ADD -> all outputs 0 immediately, depth=0, no result_valid; after release, push 9 and 1, SUB -> result_data=8.
